aes_inv_round_engine: RTL and testbench

AES_INV_ROUND_ENGINE -- requirements
Module: aes_inv_round_engine

---
 rtl/aes_inv_round_engine.sv | 146 ++++++++++++++
 tb/tb_aes_inv_round_engine.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_inv_round_engine.sv
// AES-128 inverse cipher, one round per clock; round keys are fetched from an external store by index.
// A block is accepted in IDLE, its plaintext appears 10 edges later and is held until out_ready.
module aes_inv_round_engine (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] din,
  output logic [3:0]   rk_idx,
  input  logic [127:0] rk,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] dout
);

  typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} state_e;

  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Byte (r,c) lives at bit offset 8*(15-4c-r).
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[8*(15-4*c-r) +: 8] = s[8*(15-4*((c-r+4)%4)-r) +: 8];
    return o;
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int i = 0; i < 16; i++)
      o[8*i +: 8] = INV_SBOX[s[8*i +: 8]];
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a [4];
    logic [7:0]   x2 [4];
    logic [7:0]   x4 [4];
    logic [7:0]   x8 [4];
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int j = 0; j < 4; j++) begin
        a[j]  = s[8*(15-4*c-j) +: 8];
        x2[j] = xt(a[j]);
        x4[j] = xt(x2[j]);
        x8[j] = xt(x4[j]);
      end
      // Row r weights: 0e on a[r], 0b on a[r+1], 0d on a[r+2], 09 on a[r+3].
      for (int r = 0; r < 4; r++)
        o[8*(15-4*c-r) +: 8] = (x8[r] ^ x4[r] ^ x2[r])
                             ^ (x8[(r+1)%4] ^ x2[(r+1)%4] ^ a[(r+1)%4])
                             ^ (x8[(r+2)%4] ^ x4[(r+2)%4] ^ a[(r+2)%4])
                             ^ (x8[(r+3)%4] ^ a[(r+3)%4]);
    end
    return o;
  endfunction

  state_e       state_q, state_d;
  logic [3:0]   rnd_q, rnd_d;
  logic [127:0] blk_q, blk_d;
  logic [127:0] round_core;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rnd_q   <= 4'd0;
      blk_q   <= 128'd0;
    end else begin
      state_q <= state_d;
      rnd_q   <= rnd_d;
      blk_q   <= blk_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    rnd_d      = rnd_q;
    blk_d      = blk_q;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    rk_idx     = 4'd10;
    round_core = inv_sub_bytes(inv_shift_rows(blk_q)) ^ rk;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        rk_idx   = 4'd10;
        if (in_valid) begin
          blk_d   = din ^ rk;
          rnd_d   = 4'd9;
          state_d = ROUND;
        end
      end
      ROUND: begin
        rk_idx = rnd_q;
        blk_d  = inv_mix_columns(round_core);
        rnd_d  = rnd_q - 4'd1;
        if (rnd_q == 4'd1) state_d = FINAL;
      end
      FINAL: begin
        rk_idx  = 4'd0;
        blk_d   = round_core;
        state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        rk_idx    = 4'd0;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Reset masks handshakes immediately, not only after the next edge.
    if (rst) begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      rk_idx    = 4'd10;
    end
  end

  assign dout = out_valid ? blk_q : 128'd0;

endmodule

// File: tb/tb_aes_inv_round_engine.sv
// Scoreboard bench for aes_inv_round_engine with a behavioural AES-128 inverse-cipher model
// and a key store that answers rk_idx from a per-key expanded schedule.
module tb_aes_inv_round_engine;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] din;
  logic [3:0]   rk_idx;
  logic [127:0] rk;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] dout;

  aes_inv_round_engine dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .din(din),
    .rk_idx(rk_idx), .rk(rk), .out_valid(out_valid), .out_ready(out_ready), .dout(dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  bit or_rand = 1'b0;

  logic [7:0]   fwd_sb [256];
  logic [7:0]   inv_sb [256];
  logic [127:0] rkeys [11];
  logic [127:0] rk_noise = 128'd0;
  logic [127:0] exp_q [$];

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) rk_noise <= {$urandom, $urandom, $urandom, $urandom};
  always @(posedge clk) begin
    #1;
    if (or_rand) out_ready = 1'($urandom_range(0, 1));
  end

  // The DONE state never samples rk, so feed it garbage there.
  assign rk = out_valid ? rk_noise : ((rk_idx <= 4'd10) ? rkeys[rk_idx] : 128'd0);

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] d;
    d = {b, b} << n;
    return d[15:8];
  endfunction

  task automatic build_sboxes();
    logic [7:0] inv;
    logic [7:0] s;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int b = 1; b < 256; b++)
        if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      fwd_sb[a] = s;
      inv_sb[s] = 8'(a);
    end
  endtask

  task automatic set_key(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rcon;
    rcon = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {fwd_sb[t[31:24]], fwd_sb[t[23:16]], fwd_sb[t[15:8]], fwd_sb[t[7:0]]} ^ {rcon, 24'h0};
        rcon = gmul(rcon, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) rkeys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [7:0] getb(input logic [127:0] s, input int r, input int c);
    return s[127-8*(4*c+r) -: 8];
  endfunction

  function automatic logic [127:0] ref_decrypt(input logic [127:0] ct);
    logic [127:0] s;
    logic [127:0] t;
    logic [7:0]   coef [4];
    logic [7:0]   acc;
    coef[0] = 8'h0e; coef[1] = 8'h0b; coef[2] = 8'h0d; coef[3] = 8'h09;
    s = ct ^ rkeys[10];
    for (int rnd = 9; rnd >= 0; rnd--) begin
      t = '0;
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          t[127-8*(4*c+r) -: 8] = inv_sb[getb(s, r, (c - r + 4) % 4)];
      s = t ^ rkeys[rnd];
      if (rnd > 0) begin
        t = '0;
        for (int c = 0; c < 4; c++)
          for (int r = 0; r < 4; r++) begin
            acc = 8'h00;
            for (int j = 0; j < 4; j++) acc = acc ^ gmul(coef[(j - r + 4) % 4], getb(s, j, c));
            t[127-8*(4*c+r) -: 8] = acc;
          end
        s = t;
      end
    end
    return s;
  endfunction

  // ---------------- monitor ----------------
  int           tr = -1;
  int           acc_cyc = 0;
  bit           acc_pend = 1'b0;
  logic         ov_prev = 1'b0;
  logic         or_prev = 1'b0;
  logic [127:0] dout_prev = 128'd0;
  logic [127:0] e;

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_in_ready", 128'(in_ready), 128'd0);
      chk("rst_out_valid", 128'(out_valid), 128'd0);
      chk("rst_dout", dout, 128'd0);
      chk("rst_rk_idx", 128'(rk_idx), 128'd10);
      tr = -1; acc_pend = 1'b0; ov_prev = 1'b0; or_prev = 1'b0; dout_prev = 128'd0;
    end else begin
      if (tr >= 0) begin
        chk("rk_idx_trace", 128'(rk_idx), 128'(tr));
        chk("busy_in_ready", 128'(in_ready), 128'd0);
        tr--;
      end
      if (in_valid && in_ready) begin
        chk("accept_rk_idx", 128'(rk_idx), 128'd10);
        tr = 9;
        acc_cyc = cyc;
        acc_pend = 1'b1;
      end
      if (!out_valid) chk("dout_zero_when_invalid", dout, 128'd0);
      if (ov_prev && !or_prev) begin
        chk("hold_out_valid", 128'(out_valid), 128'd1);
        chk("hold_dout", dout, dout_prev);
      end
      if (out_valid && !ov_prev) begin
        if (!acc_pend) chk("spurious_out_valid", 128'(out_valid), 128'd0);
        else chk("out_valid_latency", 128'(cyc), 128'(acc_cyc + 11));
        acc_pend = 1'b0;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("output_without_block", 128'(out_valid), 128'd0);
        else begin
          e = exp_q.pop_front();
          chk("dout", dout, e);
        end
      end
      ov_prev = out_valid; or_prev = out_ready; dout_prev = dout;
    end
  end

  // ---------------- driver ----------------
  task automatic send(input logic [127:0] ct, input logic [127:0] exp, input bit keep_valid, output int acc);
    bit ok;
    ok = 1'b0;
    acc = 0;
    in_valid = 1'b1;
    din = ct;
    for (int n = 0; n < 60 && !ok; n++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        acc = cyc;
      end
    end
    if (!ok) begin
      chk("accept_timeout", 128'(in_ready), 128'd1);
      in_valid = 1'b0;
    end else begin
      exp_q.push_back(exp);
      @(posedge clk); #1;
      if (!keep_valid) in_valid = 1'b0;
    end
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 300 && !ok; n++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && in_ready) ok = 1'b1;
    end
    if (!ok) chk("idle_timeout", 128'(in_ready), 128'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [127:0] ct, ct2, ex, ex2;
    int a1, a2;
    bit ok;
    rst = 1'b1; in_valid = 1'b0; din = 128'd0; out_ready = 1'b0;
    build_sboxes();
    set_key(128'h000102030405060708090a0b0c0d0e0f);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("in_ready_after_reset", 128'(in_ready), 128'd1);
    @(posedge clk); #1;

    // FIPS-197 C.1 and B known answers
    out_ready = 1'b1;
    send(128'h69c4e0d86a7b0430d8cdb78070b4c55a, 128'h00112233445566778899aabbccddeeff, 1'b0, a1);
    wait_idle();
    set_key(128'h2b7e151628aed2a6abf7158809cf4f3c);
    send(128'h3925841d02dc09fbdc118597196a0b32, 128'h3243f6a8885a308d313198a2e0370734, 1'b0, a1);
    wait_idle();

    // Backpressure: five DONE cycles with out_ready low, then a one-cycle pulse
    set_key({$urandom, $urandom, $urandom, $urandom});
    ct = {$urandom, $urandom, $urandom, $urandom};
    out_ready = 1'b0;
    send(ct, ref_decrypt(ct), 1'b0, a1);
    ok = 1'b0;
    for (int n = 0; n < 40 && !ok; n++) begin
      @(negedge clk);
      if (out_valid) ok = 1'b1;
    end
    if (!ok) chk("bp_out_valid_timeout", 128'(out_valid), 128'd1);
    repeat (4) @(negedge clk);
    @(posedge clk); #1 out_ready = 1'b1;
    @(posedge clk); #1 out_ready = 1'b0;
    @(negedge clk);
    chk("bp_in_ready_next", 128'(in_ready), 128'd1);
    chk("bp_out_valid_dropped", 128'(out_valid), 128'd0);
    @(posedge clk); #1;

    // Back-to-back with in_valid held high
    out_ready = 1'b1;
    ct = {$urandom, $urandom, $urandom, $urandom};
    ct2 = {$urandom, $urandom, $urandom, $urandom};
    ex = ref_decrypt(ct);
    ex2 = ref_decrypt(ct2);
    send(ct, ex, 1'b1, a1);
    send(ct2, ex2, 1'b0, a2);
    chk("b2b_spacing", 128'(a2 - a1), 128'd12);
    wait_idle();

    // in_valid/din noise while busy must not disturb the block
    ct = {$urandom, $urandom, $urandom, $urandom};
    send(ct, ref_decrypt(ct), 1'b0, a1);
    repeat (8) begin
      in_valid = 1'($urandom_range(0, 1));
      din = {$urandom, $urandom, $urandom, $urandom};
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    wait_idle();

    // Random keys and blocks with random out_ready
    for (int k = 0; k < 6; k++) begin
      set_key({$urandom, $urandom, $urandom, $urandom});
      ct = {$urandom, $urandom, $urandom, $urandom};
      or_rand = 1'b1;
      send(ct, ref_decrypt(ct), 1'b0, a1);
      wait_idle();
      or_rand = 1'b0;
    end

    // Reset during the 4th ROUND cycle aborts the block
    out_ready = 1'b1;
    ct = {$urandom, $urandom, $urandom, $urandom};
    send(ct, ref_decrypt(ct), 1'b0, a1);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    exp_q.delete();
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_in_ready_after_rst", 128'(in_ready), 128'd1);
    repeat (15) @(negedge clk);
    chk("abort_no_out_valid", 128'(out_valid), 128'd0);
    chk("abort_rk_idx", 128'(rk_idx), 128'd10);
    @(posedge clk); #1;
    ct = {$urandom, $urandom, $urandom, $urandom};
    send(ct, ref_decrypt(ct), 1'b0, a1);
    wait_idle();

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
